delay_slot_sched: RTL and testbench

Sequencer for branch delay slots in the multi-cycle reference CPU. The branch handler resolves a branch target and returns the core to fetch without committing. This block holds that target while the delay-slot instruction runs. When the delay slot commits, it issues a one-cycle PC redirect. It also supplies the BD flag for exception reporting and traps the UNPREDICTABLE case of a branch inside a delay slot.

---
 rtl/delay_slot_sched_pkg.sv | 19 +
 rtl/delay_slot_sched_if.sv | 30 +++
 rtl/delay_slot_sched_stat.sv | 22 ++
 rtl/delay_slot_sched.sv | 124 ++++++++++++
 tb/tb_delay_slot_sched.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/delay_slot_sched_pkg.sv
// Shared types and constants for the branch delay-slot sequencer.
// Optional statistics counters are enabled with REFCPU_BRANCH_STATS_EN.
package delay_slot_sched_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned STAT_W = 32;

    typedef logic [ADDR_W-1:0] addr_t;

    localparam addr_t RESET_PC = 32'hbfc0_0000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_DS  = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_ERROR    = 2'd3
    } ds_state_t;

endpackage

// File: rtl/delay_slot_sched_if.sv
// Branch/commit/flush bundle between the core control and the delay-slot sequencer.
interface delay_slot_sched_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              br_valid;
    logic [ADDR_W-1:0] br_pc;
    logic [ADDR_W-1:0] br_target;
    logic              commit_valid;
    logic [ADDR_W-1:0] commit_pc;
    logic              flush;
    logic [ADDR_W-1:0] flush_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              in_delay_slot;
    logic [ADDR_W-1:0] ds_pc;
    logic              busy;
    logic              err_nested;

    // Core side: reports branches, commits and flushes; consumes redirects.
    modport master (
        output br_valid, br_pc, br_target, commit_valid, commit_pc, flush, flush_pc,
        input  redirect_valid, redirect_pc, in_delay_slot, ds_pc, busy, err_nested
    );

    // Sequencer side.
    modport slave (
        input  br_valid, br_pc, br_target, commit_valid, commit_pc, flush, flush_pc,
        output redirect_valid, redirect_pc, in_delay_slot, ds_pc, busy, err_nested
    );
endinterface

// File: rtl/delay_slot_sched_stat.sv
// Free-running wrapping event counter, only built when REFCPU_BRANCH_STATS_EN is defined.
`ifdef REFCPU_BRANCH_STATS_EN
module ds_stat_counter
    import delay_slot_sched_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic [STAT_W-1:0] count
);

    // Count one per enabled cycle, wrapping at 2^STAT_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= count + STAT_W'(1);
        end
    end

endmodule
`endif

// File: rtl/delay_slot_sched.sv
// Branch delay-slot sequencer: holds a resolved branch target until the
// delay-slot instruction commits, then issues a one-cycle PC redirect.
// Flushes win over everything and redirect one cycle later; a branch inside
// a delay slot locks the block in ERROR until reset.
// Optional counters: define REFCPU_BRANCH_STATS_EN.
module delay_slot_sched #(
    parameter int unsigned            ADDR_W   = delay_slot_sched_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0]      RESET_PC = ADDR_W'(delay_slot_sched_pkg::RESET_PC)
) (
    input  logic        clk,
    input  logic        reset,
`ifdef REFCPU_BRANCH_STATS_EN
    output logic [31:0] stat_branches,
    output logic [31:0] stat_flushed,
`endif
    delay_slot_sched_if.slave bus
);

    import delay_slot_sched_pkg::*;

    ds_state_t         state_q;
    ds_state_t         state_d;
    logic              accept_br;
    logic              take_flush;
    logic [ADDR_W-1:0] target_q;
    logic [ADDR_W-1:0] ds_pc_q;
    logic              flush_q;
    logic [ADDR_W-1:0] flush_pc_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: flush first, then branch, then delay-slot commit.
    always_comb begin
        state_d    = state_q;
        accept_br  = 1'b0;
        take_flush = 1'b0;
        case (state_q)
            ST_IDLE, ST_REDIRECT: begin
                if (bus.flush) begin
                    take_flush = 1'b1;
                    state_d    = ST_IDLE;
                end else if (bus.br_valid) begin
                    accept_br = 1'b1;
                    state_d   = ST_WAIT_DS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_DS: begin
                if (bus.flush) begin
                    take_flush = 1'b1;
                    state_d    = ST_IDLE;
                end else if (bus.br_valid) begin
                    state_d = ST_ERROR;
                end else if (bus.commit_valid && (bus.commit_pc == ds_pc_q)) begin
                    state_d = ST_REDIRECT;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Branch target / delay-slot PC capture and the one-cycle flush redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target_q   <= '0;
            ds_pc_q    <= '0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
        end else begin
            flush_q <= take_flush;
            if (take_flush) begin
                flush_pc_q <= bus.flush_pc;
                target_q   <= '0;
            end else if (accept_br) begin
                target_q <= bus.br_target;
                ds_pc_q  <= bus.br_pc + ADDR_W'(4);
            end
        end
    end

    // Outputs come from registers only; flush and branch redirects never overlap.
    assign bus.redirect_valid = flush_q || (state_q == ST_REDIRECT);
    assign bus.redirect_pc    = flush_q                  ? flush_pc_q :
                                (state_q == ST_REDIRECT) ? target_q   : RESET_PC;
    assign bus.in_delay_slot  = (state_q == ST_WAIT_DS);
    assign bus.ds_pc          = ds_pc_q;
    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.err_nested     = (state_q == ST_ERROR);

`ifdef REFCPU_BRANCH_STATS_EN
    logic ds_flushed;

    // A flush only discards a delay slot when one is actually pending.
    assign ds_flushed = take_flush && (state_q == ST_WAIT_DS);

    ds_stat_counter u_stat_branches (
        .clk   (clk),
        .reset (reset),
        .en    (accept_br),
        .count (stat_branches)
    );

    ds_stat_counter u_stat_flushed (
        .clk   (clk),
        .reset (reset),
        .en    (ds_flushed),
        .count (stat_flushed)
    );
`endif

endmodule

// File: tb/tb_delay_slot_sched.sv
// Bench for delay_slot_sched: directed vector table, async-reset abort, and
// randomized traffic against a pending-slot reference model.
// Build with REFCPU_BRANCH_STATS_EN to also cover the statistics counters.
module tb_delay_slot_sched;

    typedef logic [31:0] addr_t;

    localparam addr_t RST_PC = 32'hbfc0_0000;

    typedef struct {
        logic  br;
        addr_t br_pc;
        addr_t br_tgt;
        logic  cm;
        addr_t cm_pc;
        logic  fl;
        addr_t fl_pc;
    } stim_t;

    typedef struct {
        stim_t s;
        logic  rv;
        logic  chk_rpc;
        addr_t rpc;
        logic  ids;
        addr_t ds;
        logic  busy;
        logic  err;
    } vec_t;

    logic clk;
    logic reset;

    delay_slot_sched_if #(.ADDR_W(32)) bus ();

`ifdef REFCPU_BRANCH_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_flushed;
`endif

    delay_slot_sched dut (
        .clk           (clk),
        .reset         (reset),
`ifdef REFCPU_BRANCH_STATS_EN
        .stat_branches (stat_branches),
        .stat_flushed  (stat_flushed),
`endif
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a pending delay slot, an error latch and the redirect to show.
    logic  m_err;
    logic  m_pend;
    addr_t m_ds;
    addr_t m_tgt;
    logic  m_out_v;
    addr_t m_out_pc;
    logic  m_from_br;
    int unsigned m_stat_b;
    int unsigned m_stat_f;

    function automatic stim_t S(input logic br, input addr_t bp, input addr_t bt,
                                input logic cm, input addr_t cp,
                                input logic fl, input addr_t fp);
        stim_t r;
        r.br = br; r.br_pc = bp; r.br_tgt = bt;
        r.cm = cm; r.cm_pc = cp; r.fl = fl; r.fl_pc = fp;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_err = 1'b0; m_pend = 1'b0; m_ds = '0; m_tgt = '0;
        m_out_v = 1'b0; m_out_pc = RST_PC; m_from_br = 1'b0;
        m_stat_b = 0; m_stat_f = 0;
    endtask

    // One clock of the architectural rules, applied to the inputs of that clock.
    task automatic model_step(input stim_t s);
        logic  nv;
        addr_t npc;
        logic  nbr;
        nv = 1'b0; npc = RST_PC; nbr = 1'b0;
        if (!m_err) begin
            if (s.fl) begin
                if (m_pend) m_stat_f++;
                m_pend = 1'b0;
                nv = 1'b1; npc = s.fl_pc;
            end else if (m_pend) begin
                if (s.br) begin
                    m_err = 1'b1; m_pend = 1'b0;
                end else if (s.cm && s.cm_pc == m_ds) begin
                    m_pend = 1'b0;
                    nv = 1'b1; npc = m_tgt; nbr = 1'b1;
                end
            end else if (s.br) begin
                m_pend = 1'b1;
                m_ds   = s.br_pc + 32'd4;
                m_tgt  = s.br_tgt;
                m_stat_b++;
            end
        end
        m_out_v = nv; m_out_pc = npc; m_from_br = nbr;
    endtask

    task automatic model_check();
        logic m_busy;
        m_busy = m_pend || m_from_br || m_err;
        chk("redirect_valid", 32'(bus.redirect_valid), 32'(m_out_v));
        if (m_out_v)      chk("redirect_pc", bus.redirect_pc, m_out_pc);
        else if (!m_busy) chk("redirect_pc_idle", bus.redirect_pc, RST_PC);
        chk("in_delay_slot", 32'(bus.in_delay_slot), 32'(m_pend));
        chk("ds_pc", bus.ds_pc, m_ds);
        chk("busy", 32'(bus.busy), 32'(m_busy));
        chk("err_nested", 32'(bus.err_nested), 32'(m_err));
`ifdef REFCPU_BRANCH_STATS_EN
        chk("stat_branches", stat_branches, m_stat_b);
        chk("stat_flushed", stat_flushed, m_stat_f);
`endif
    endtask

    task automatic drive(input stim_t s);
        bus.br_valid     = s.br;
        bus.br_pc        = s.br_pc;
        bus.br_target    = s.br_tgt;
        bus.commit_valid = s.cm;
        bus.commit_pc    = s.cm_pc;
        bus.flush        = s.fl;
        bus.flush_pc     = s.fl_pc;
    endtask

    // Apply inputs for one clock, then sample just after the edge.
    task automatic step(input stim_t s);
        drive(s);
        model_step(s);
        @(posedge clk);
        #1;
        model_check();
    endtask

    task automatic do_reset();
        drive(S(0, 0, 0, 0, 0, 0, 0));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        model_check();
    endtask

    vec_t tbl[17];

    initial begin
        stim_t s;

        // Directed sequence; expectations are the outputs after that row's clock.
        tbl[0]  = '{S(0, 0, 0, 0, 0, 0, 0),                      0, 1, RST_PC,        0, 32'h0,    0, 0};
        tbl[1]  = '{S(1, 32'h100, 32'h200, 0, 0, 0, 0),          0, 0, 0,             1, 32'h104,  1, 0};
        tbl[2]  = '{S(0, 0, 0, 1, 32'h100, 0, 0),                0, 0, 0,             1, 32'h104,  1, 0};
        tbl[3]  = '{S(0, 0, 0, 1, 32'h104, 0, 0),                1, 1, 32'h200,       0, 32'h104,  1, 0};
        tbl[4]  = '{S(0, 0, 0, 0, 0, 0, 0),                      0, 1, RST_PC,        0, 32'h104,  0, 0};
        tbl[5]  = '{S(1, 32'hffff_fffc, 32'h40, 0, 0, 0, 0),     0, 0, 0,             1, 32'h0,    1, 0};
        tbl[6]  = '{S(0, 0, 0, 1, 32'h0, 0, 0),                  1, 1, 32'h40,        0, 32'h0,    1, 0};
        tbl[7]  = '{S(1, 32'h300, 32'h500, 0, 0, 0, 0),          0, 0, 0,             1, 32'h304,  1, 0};
        tbl[8]  = '{S(0, 0, 0, 1, 32'h304, 0, 0),                1, 1, 32'h500,       0, 32'h304,  1, 0};
        tbl[9]  = '{S(0, 0, 0, 0, 0, 0, 0),                      0, 1, RST_PC,        0, 32'h304,  0, 0};
        tbl[10] = '{S(1, 32'h1000, 32'h2000, 0, 0, 0, 0),        0, 0, 0,             1, 32'h1004, 1, 0};
        tbl[11] = '{S(0, 0, 0, 0, 0, 1, 32'hbfc0_0380),          1, 1, 32'hbfc0_0380, 0, 32'h1004, 0, 0};
        tbl[12] = '{S(0, 0, 0, 1, 32'h1004, 0, 0),               0, 1, RST_PC,        0, 32'h1004, 0, 0};
        tbl[13] = '{S(1, 32'h10, 32'h20, 0, 0, 0, 0),            0, 0, 0,             1, 32'h14,   1, 0};
        tbl[14] = '{S(1, 32'h40, 32'h80, 0, 0, 0, 0),            0, 0, 0,             0, 32'h14,   1, 1};
        tbl[15] = '{S(0, 0, 0, 1, 32'h14, 0, 0),                 0, 0, 0,             0, 32'h14,   1, 1};
        tbl[16] = '{S(0, 0, 0, 0, 0, 1, 32'h5),                  0, 0, 0,             0, 32'h14,   1, 1};

        reset = 1'b1;
        drive(S(0, 0, 0, 0, 0, 0, 0));
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        chk("reset_redirect_pc", bus.redirect_pc, RST_PC);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        model_check();

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].s);
            chk($sformatf("tbl%0d_redirect_valid", i), 32'(bus.redirect_valid), 32'(tbl[i].rv));
            if (tbl[i].chk_rpc)
                chk($sformatf("tbl%0d_redirect_pc", i), bus.redirect_pc, tbl[i].rpc);
            chk($sformatf("tbl%0d_in_delay_slot", i), 32'(bus.in_delay_slot), 32'(tbl[i].ids));
            chk($sformatf("tbl%0d_ds_pc", i), bus.ds_pc, tbl[i].ds);
            chk($sformatf("tbl%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_err_nested", i), 32'(bus.err_nested), 32'(tbl[i].err));
        end
`ifdef REFCPU_BRANCH_STATS_EN
        chk("tbl_stat_branches", stat_branches, 32'd5);
        chk("tbl_stat_flushed", stat_flushed, 32'd1);
`endif

        // Reset clears the error and aborts a redirect that is on the output.
        do_reset();
        step(S(1, 32'h700, 32'h900, 0, 0, 0, 0));
        step(S(0, 0, 0, 1, 32'h704, 0, 0));
        chk("pre_abort_redirect_valid", 32'(bus.redirect_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        chk("abort_redirect_pc", bus.redirect_pc, RST_PC);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        do_reset();

        // Branch right after a flush redirect and after a branch redirect.
        step(S(1, 32'h2000, 32'h3000, 0, 0, 0, 0));
        step(S(1, 32'h2004, 32'h4000, 0, 0, 1, 32'h80));
        step(S(1, 32'h5000, 32'h6000, 0, 0, 0, 0));
        chk("br_after_flush_ids", 32'(bus.in_delay_slot), 32'd1);
        step(S(0, 0, 0, 1, 32'h5004, 0, 0));
        step(S(0, 0, 0, 1, 32'h5004, 1, 32'h90));
        chk("flush_in_redirect_pc", bus.redirect_pc, 32'h90);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            if (m_err && $urandom_range(0, 7) == 0) begin
                do_reset();
            end else begin
                s.br     = ($urandom_range(0, 99) < (m_pend ? 4 : 30));
                s.br_pc  = ($urandom_range(0, 15) == 0) ? 32'hffff_fffc : ($urandom() & 32'hffff_fffc);
                s.br_tgt = $urandom();
                s.cm     = ($urandom_range(0, 1) == 1);
                s.cm_pc  = ($urandom_range(0, 2) != 0) ? m_ds : ($urandom() & 32'hffff_fffc);
                s.fl     = ($urandom_range(0, 15) == 0);
                s.fl_pc  = $urandom();
                step(s);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
